mem_responder: RTL

- Slave end of the processor's memory bus; sits between the multicycle CPU and on-chip storage.
- Accepts single-word read/write requests and inserts WAIT_CYCLES wait states.
- Returns read data and drives the ready line that stalls the CPU step counter.
- Provides a word RAM, one memory-mapped I/O register and a sticky bus-error flag.

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_ram_1rw.sv | 23 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-bus responder: state encoding, default decode
// constants and the RAM word-index width helper.
package mem_responder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StWait = 2'd1;
   localparam state_t StResp = 2'd2;

   localparam logic [31:0] DefIoAddr = 32'hFFFF_FFF0;
   localparam logic [31:0] ErrRdata  = 32'h0000_0000;

   function automatic int unsigned word_idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_responder_ram_1rw.sv
// Single-port synchronous word RAM with write enable and registered, read-enabled output.
// Contents are not reset.
module ram_1rw #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          iClk,
   input  logic          iWe,
   input  logic          iRe,
   input  logic [AW-1:0] iAddr,
   input  logic [31:0]   iWdata,
   output logic [31:0]   oRdata
);

   logic [31:0] mem [DEPTH];

   // Output register only moves on a read so the last read word is held.
   always_ff @(posedge iClk) begin
      if (iWe) mem[iAddr] <= iWdata;
      if (iRe) oRdata <= mem[iAddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Slave end of the CPU memory bus: wait-state insertion, word RAM, one I/O register
// and a sticky bus-error flag.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] IO_ADDR     = DefIoAddr
) (
   input  logic        iClk,
   input  logic        nRst,
   input  logic [31:0] iMemAddr,
   input  logic [31:0] iMemData,
   input  logic        iMemWrite,
   input  logic        iMemRead,
   output logic [31:0] oMemData,
   output logic        oRDY,
   output logic [31:0] oIO,
   output logic        oErr
);

   localparam int unsigned Aw = word_idx_width(DEPTH);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q, hold_q, io_q;
   logic        write_q, both_q, err_q;

   logic        req;
   logic [31:0] cur_addr, cur_wdata;
   logic        cur_write, cur_both;
   logic        is_io, misal, in_ram, ram_hit, io_hit, bad;
   logic        commit, ram_we, ram_re;
   logic [31:0] ram_rdata, resp_data;

   assign req = iMemRead | iMemWrite;

   // With no wait states the access commits on the request edge, so use live inputs in IDLE.
   assign cur_addr  = (state_q == StIdle) ? iMemAddr  : addr_q;
   assign cur_wdata = (state_q == StIdle) ? iMemData  : wdata_q;
   assign cur_write = (state_q == StIdle) ? iMemWrite : write_q;
   assign cur_both  = (state_q == StIdle) ? (iMemRead & iMemWrite) : both_q;

   assign is_io   = (cur_addr == IO_ADDR);
   assign misal   = |cur_addr[1:0];
   assign in_ram  = {2'b00, cur_addr[31:2]} < DEPTH;
   assign ram_hit = !misal && !is_io && in_ram;
   assign io_hit  = !misal && is_io;
   assign bad     = misal || (!is_io && !in_ram) || cur_both;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Exactly one commit per transaction: the edge that enters RESP, never during reset.
   assign commit = nRst && (state_d == StResp) && (state_q != StResp);
   assign ram_we = commit && cur_write && ram_hit;
   assign ram_re = commit && !cur_write && ram_hit;

   ram_1rw #(
      .DEPTH (DEPTH),
      .AW    (Aw)
   ) u_ram (
      .iClk   (iClk),
      .iWe    (ram_we),
      .iRe    (ram_re),
      .iAddr  (cur_addr[Aw+1:2]),
      .iWdata (cur_wdata),
      .oRdata (ram_rdata)
   );

   always_comb begin
      resp_data = ErrRdata;
      if (cur_write)    resp_data = hold_q;
      else if (ram_hit) resp_data = ram_rdata;
      else if (io_hit)  resp_data = io_q;
   end

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         write_q <= 1'b0;
         both_q  <= 1'b0;
         hold_q  <= 32'h0;
         io_q    <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= oMemData;
         if (state_q == StIdle && req) begin
            addr_q  <= iMemAddr;
            wdata_q <= iMemData;
            write_q <= iMemWrite;
            both_q  <= iMemRead & iMemWrite;
         end
         if (commit && cur_write && io_hit) io_q <= cur_wdata;
         if (commit && bad) err_q <= 1'b1;
      end
   end

   assign oMemData = (state_q == StResp) ? resp_data : hold_q;
   assign oRDY     = nRst && ((state_q == StResp) || (state_q == StIdle && !req));
   assign oIO      = io_q;
   assign oErr     = err_q;

endmodule
